rom_stream_reader: RTL and testbench



---
 rtl/rom_stream_reader.sv | 190 +++++++++++++++++++
 tb/tb_rom_stream_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// rom_stream_reader
//
// Reads a programmable burst of consecutive words from a fixed-latency ROM.
// The returned words are buffered in a small FIFO and handed to a downstream
// consumer over a valid/ready stream. The consumer may stall freely. Read
// issue is throttled by a credit check, so the FIFO can never overflow.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous, active-high reset
//   start            one-cycle burst request, only honoured while idle
//   start_addr       first ROM address of the burst
//   length           number of words to read (0 .. 2^ADDR_WIDTH)
//   busy             high from the cycle after an accepted start until done
//   done             one-cycle pulse after the last word is accepted
//   rom_address      address to the ROM
//   rom_read_enable  read enable to the ROM
//   rom_data_out     ROM read data, valid one cycle after an issued read
//   out_data         word at the head of the FIFO (0 when empty)
//   out_valid        FIFO non-empty
//   out_ready        consumer accepts the head word when valid and ready

module rom_stream_reader #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_read_enable,
    input  logic [DATA_WIDTH-1:0] rom_data_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   LEN_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PW-1:0]         PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]         CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]         CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW:0]           CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH:0]   issue_remaining;
    logic [ADDR_WIDTH:0]   accept_remaining;
    logic                  inflight;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;

    logic [CW:0]           credit_used;
    logic                  issue;
    logic                  push;
    logic                  pop;

    // A read may only be issued if the FIFO still has room for it once the
    // read already in flight (if any) has landed. Pops in the same cycle are
    // deliberately not counted, keeping the check purely registered.
    always_comb begin
        credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
        issue       = (state == ST_READ) && (issue_remaining != '0) &&
                      (credit_used < CREDIT_MAX);
        push        = inflight;
        pop         = (fifo_count != '0) && out_ready;
    end

    // The ROM address only moves when a read is issued; otherwise it holds
    // the address of the most recent read.
    assign rom_read_enable = issue;
    assign rom_address     = issue ? addr : last_addr;

    // Empty FIFO shows zero so stale storage never leaks after a reset.
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;

    // Burst control: address/issue bookkeeping in READ, completion in DRAIN.
    // done is registered, so it appears in the cycle after the final
    // handshake, with busy dropping in that same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            addr             <= '0;
            last_addr        <= '0;
            issue_remaining  <= '0;
            accept_remaining <= '0;
            inflight         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                last_addr <= addr;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr             <= start_addr;
                            issue_remaining  <= length;
                            accept_remaining <= length;
                            busy             <= 1'b1;
                            state            <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        addr            <= addr + ADDR_ONE;
                        issue_remaining <= issue_remaining - LEN_ONE;
                        if (issue_remaining == LEN_ONE) begin
                            state <= ST_DRAIN;
                        end
                    end
                    if (pop) begin
                        accept_remaining <= accept_remaining - LEN_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (pop) begin
                        accept_remaining <= accept_remaining - LEN_ONE;
                    end
                    if ((accept_remaining == '0) ||
                        (pop && (accept_remaining == LEN_ONE))) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO storage is not reset; out_data is gated by out_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= rom_data_out;
        end
    end

    // FIFO pointers and occupancy. Depth is a power of two, so the pointers
    // wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // The credit check must make a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (rst)
                     !(push && (fifo_count == CNT_FULL)));

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader
//
// Directed bench for rom_stream_reader. A ROM model holding memory[i]=i with
// one cycle of read latency sits behind the DUT. A negedge monitor checks
// every accepted word against the expected address sequence of the current
// burst. It also counts handshakes and done pulses.

module tb_rom_stream_reader;

    localparam int AW = 14;
    localparam int DW = 24;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_address;
    logic          rom_read_enable;
    logic [DW-1:0] rom_data_out = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    int check_count = 0;
    int error_count = 0;
    int total_hs    = 0;
    int done_count  = 0;
    int base_hs     = 0;
    int base_done   = 0;
    int exp_base    = 0;

    always #5 clk = ~clk;

    rom_stream_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_addr     (start_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .rom_address    (rom_address),
        .rom_read_enable(rom_read_enable),
        .rom_data_out   (rom_data_out),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    // ROM model: memory[i] = i, latency 1. Junk appears when no read was
    // issued, so a capture without a read shows up as a wrong word.
    always @(posedge clk) begin
        if (rom_read_enable) begin
            rom_data_out <= DW'(rom_address);
        end else begin
            rom_data_out <= 24'hBADBAD;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Monitor: the inputs only change just after posedge, so what is seen at
    // negedge is exactly what the DUT samples at the following posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_count++;
            end
            if (out_valid && out_ready) begin
                checkOutput("word", 32'(out_data),
                            32'((exp_base + total_hs - base_hs) & 32'h3FFF));
                total_hs++;
            end
        end
    end

    // Presents a one-cycle start. Returns just after the edge that sampled
    // it, so the next negedge is sample point k=0.
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [AW:0] len);
        @(posedge clk);
        #1;
        start_addr = addr;
        length     = len;
        start      = 1'b1;
        exp_base   = int'(addr);
        base_hs    = total_hs;
        base_done  = done_count;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done, recording when it arrived and what happened on the
    // way. Optionally randomises out_ready each cycle.
    task automatic waitDone(input string tag, input int max_cycles, input bit rand_ready,
                            output int done_k, output int first_valid_k,
                            output int busy_high, output int ren_count,
                            output int busy_at_done);
        done_k        = -1;
        first_valid_k = -1;
        busy_high     = 0;
        ren_count     = 0;
        busy_at_done  = 1;
        for (int k = 0; k < max_cycles; k++) begin
            @(negedge clk);
            if (out_valid && (first_valid_k < 0)) first_valid_k = k;
            if (rom_read_enable) ren_count++;
            if (done) begin
                done_k       = k;
                busy_at_done = int'(busy);
                break;
            end
            if (busy) busy_high++;
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        #1;
        if (done_k < 0) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dk, fv, bh, rc, bd, ren_stall;
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        out_ready  = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy",  32'(busy), 32'd0);
        checkOutput("rst_done",  32'(done), 32'd0);
        checkOutput("rst_ren",   32'(rom_read_enable), 32'd0);
        checkOutput("rst_addr",  32'(rom_address), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data",  32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycles(2);

        // Basic burst: 0..7, consumer always ready
        applyStimulus(14'h0000, 15'd8);
        waitDone("b8", 100, 1'b0, dk, fv, bh, rc, bd);
        checkOutput("b8_done_k",    32'(dk), 32'd10);
        checkOutput("b8_first_vld", 32'(fv), 32'd2);
        checkOutput("b8_busy_high", 32'(bh), 32'd10);
        checkOutput("b8_busy_done", 32'(bd), 32'd0);
        checkOutput("b8_reads",     32'(rc), 32'd8);
        checkOutput("b8_words",     32'(total_hs - base_hs), 32'd8);
        idleCycles(3);
        checkOutput("b8_done_cnt",  32'(done_count - base_done), 32'd1);

        // Burst crossing the top of the address space
        applyStimulus(14'h3FFE, 15'd4);
        waitDone("wrap", 100, 1'b0, dk, fv, bh, rc, bd);
        checkOutput("wrap_done_k",  32'(dk), 32'd6);
        checkOutput("wrap_words",   32'(total_hs - base_hs), 32'd4);
        idleCycles(3);
        checkOutput("wrap_done_cnt", 32'(done_count - base_done), 32'd1);

        // Stalled consumer: only FIFO_DEPTH reads may be issued
        out_ready = 1'b0;
        applyStimulus(14'h0000, 15'd16);
        ren_stall = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rom_read_enable) ren_stall++;
        end
        checkOutput("stall_reads", 32'(ren_stall), 32'd4);
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_data",  32'(out_data), 32'd0);
        checkOutput("stall_words", 32'(total_hs - base_hs), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDone("stall", 200, 1'b0, dk, fv, bh, rc, bd);
        checkOutput("stall_total_reads", 32'(ren_stall + rc), 32'd16);
        checkOutput("stall_total_words", 32'(total_hs - base_hs), 32'd16);
        idleCycles(3);
        checkOutput("stall_done_cnt", 32'(done_count - base_done), 32'd1);

        // Full ROM with a randomly stalling consumer
        applyStimulus(14'h0000, 15'd16384);
        waitDone("full", 60000, 1'b1, dk, fv, bh, rc, bd);
        out_ready = 1'b1;
        checkOutput("full_words",     32'(total_hs - base_hs), 32'd16384);
        checkOutput("full_reads",     32'(rc), 32'd16384);
        checkOutput("full_busy_done", 32'(bd), 32'd0);
        idleCycles(3);
        checkOutput("full_done_cnt",  32'(done_count - base_done), 32'd1);

        // Zero-length request
        applyStimulus(14'h0123, 15'd0);
        waitDone("zero", 10, 1'b0, dk, fv, bh, rc, bd);
        checkOutput("zero_done_k", 32'(dk), 32'd0);
        checkOutput("zero_busy",   32'(bh + bd), 32'd0);
        checkOutput("zero_reads",  32'(rc), 32'd0);
        idleCycles(3);
        checkOutput("zero_done_cnt", 32'(done_count - base_done), 32'd1);

        // Reset in the middle of a burst, then a fresh short burst
        applyStimulus(14'h0000, 15'd16);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if ((total_hs - base_hs) >= 3) begin
                    seen = 1'b1;
                    break;
                end
            end
            checkOutput("mid_three_words", 32'(seen), 32'd1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy",  32'(busy), 32'd0);
        checkOutput("mid_rst_done",  32'(done), 32'd0);
        checkOutput("mid_rst_ren",   32'(rom_read_enable), 32'd0);
        checkOutput("mid_rst_addr",  32'(rom_address), 32'd0);
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_data",  32'(out_data), 32'd0);
        base_done = done_count;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycles(5);
        checkOutput("mid_no_done", 32'(done_count - base_done), 32'd0);

        applyStimulus(14'h0005, 15'd2);
        waitDone("post", 100, 1'b0, dk, fv, bh, rc, bd);
        checkOutput("post_done_k", 32'(dk), 32'd4);
        checkOutput("post_words",  32'(total_hs - base_hs), 32'd2);
        idleCycles(3);
        checkOutput("post_done_cnt", 32'(done_count - base_done), 32'd1);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
